// File: rtl/fa.sv
// Parameterizable ripple-carry full adder with a combinational sum/carry and a registered copy.
// Optional FA_OVF_EN macro adds signed-overflow outputs Ovf and Ovf_r.
module fa #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [WIDTH-1:0] S_r,
  output logic             Cout_r,
  output logic             vld_r
`ifdef FA_OVF_EN
  ,
  output logic             Ovf,
  output logic             Ovf_r
`endif
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0] c;

  assign c[0] = Cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic prop;
      assign prop       = A[gi] ^ B[gi];
      assign S[gi]      = prop ^ c[gi];
      // Propagate passes the incoming carry; otherwise A==B and A itself is the generate term.
      assign c[gi+1]    = prop ? c[gi] : A[gi];
    end
  endgenerate

  assign Cout = c[WIDTH];

  logic [WIDTH-1:0] s_r_reg;
  logic             cout_r_reg;
  logic             vld_r_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_r_reg    <= '0;
      cout_r_reg <= 1'b0;
      vld_r_reg  <= 1'b0;
    end else begin
      s_r_reg    <= S;
      cout_r_reg <= Cout;
      vld_r_reg  <= 1'b1;
    end
  end

  assign S_r    = s_r_reg;
  assign Cout_r = cout_r_reg;
  assign vld_r  = vld_r_reg;

`ifdef FA_OVF_EN
  logic ovf_r_reg;

  // For WIDTH=1 the carry into the MSB is Cin itself.
  assign Ovf = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r_reg <= 1'b0;
    end else begin
      ovf_r_reg <= Ovf;
    end
  end

  assign Ovf_r = ovf_r_reg;
`endif

endmodule

// File: tb/tb_fa.sv
// Self-checking bench for fa: a 1-bit and an 8-bit instance checked against an arithmetic model.
// Ovf checks are compiled in when FA_OVF_EN is defined.
module tb_fa;

  logic       clk;
  logic       rst;
  logic       clk_run;
  logic       chk_en;

  logic       a1, b1, cin1, s1, cout1, sr1, coutr1, vld1;
  logic [7:0] a8, b8, s8, sr8;
  logic       cin8, cout8, coutr8, vld8;
`ifdef FA_OVF_EN
  logic       ovf1, ovfr1, ovf8, ovfr8;
`endif

  int vectors;
  int miscompares;

  fa #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1),
    .S(s1), .Cout(cout1), .S_r(sr1), .Cout_r(coutr1), .vld_r(vld1)
`ifdef FA_OVF_EN
    , .Ovf(ovf1), .Ovf_r(ovfr1)
`endif
  );

  fa #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8),
    .S(s8), .Cout(cout8), .S_r(sr8), .Cout_r(coutr8), .vld_r(vld8)
`ifdef FA_OVF_EN
    , .Ovf(ovf8), .Ovf_r(ovfr8)
`endif
  );

  initial clk = 1'b0;
  always begin
    wait (clk_run);
    #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: plain unsigned addition at WIDTH+1 bits.
  function automatic logic [8:0] sum8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

  function automatic logic [1:0] sum1(input logic a, input logic b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {1'b0, cin};
  endfunction

  // Model: signed overflow means the true signed result leaves the representable range.
  function automatic logic ovf_model(input int w, input logic [7:0] a, input logic [7:0] b, input logic cin);
    int sa, sb, tot, lo, hi;
    sa  = (a[w-1]) ? int'(a) - (1 << w) : int'(a);
    sb  = (b[w-1]) ? int'(b) - (1 << w) : int'(b);
    tot = sa + sb + int'(cin);
    lo  = -(1 << (w - 1));
    hi  = (1 << (w - 1)) - 1;
    return (tot < lo) || (tot > hi);
  endfunction

  // Expected registered state: one edge behind the model, cleared by reset.
  logic [7:0] esr8;
  logic       ecr8, esr1, ecr1, ev, exp_known;
  logic       eor8, eor1;

  always @(posedge clk) begin
    if (clk_run) begin
      if (rst) begin
        esr8 <= '0; ecr8 <= 1'b0; esr1 <= 1'b0; ecr1 <= 1'b0; ev <= 1'b0;
        eor8 <= 1'b0; eor1 <= 1'b0;
      end else begin
        {ecr8, esr8} <= sum8(a8, b8, cin8);
        {ecr1, esr1} <= sum1(a1, b1, cin1);
        eor8 <= ovf_model(8, a8, b8, cin8);
        eor1 <= ovf_model(1, {7'd0, a1}, {7'd0, b1}, cin1);
        ev   <= 1'b1;
      end
      exp_known <= 1'b1;
    end
  end

  // Continuous compare against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s8_model",    {55'd0, cout8, s8}, {55'd0, sum8(a8, b8, cin8)});
      chk("s1_model",    {62'd0, cout1, s1}, {62'd0, sum1(a1, b1, cin1)});
`ifdef FA_OVF_EN
      chk("ovf8_model",  {63'd0, ovf8}, {63'd0, ovf_model(8, a8, b8, cin8)});
      chk("ovf1_model",  {63'd0, ovf1}, {63'd0, ovf_model(1, {7'd0, a1}, {7'd0, b1}, cin1)});
`endif
      if (exp_known) begin
        chk("reg8_model",  {54'd0, vld8, coutr8, sr8}, {54'd0, ev, ecr8, esr8});
        chk("reg1_model",  {61'd0, vld1, coutr1, sr1}, {61'd0, ev, ecr1, esr1});
`ifdef FA_OVF_EN
        chk("ovfr8_model", {63'd0, ovfr8}, {63'd0, eor8});
        chk("ovfr1_model", {63'd0, ovfr1}, {63'd0, eor1});
`endif
      end
    end
  end

  logic [7:0] tbl_a [4] = '{8'h55, 8'h3C, 8'h80, 8'h7E};
  logic [7:0] tbl_b [4] = '{8'hAA, 8'h0F, 8'h7F, 8'h01};
  logic       tbl_c [4] = '{1'b0,  1'b1,  1'b1,  1'b1};

  initial begin
    vectors = 0; miscompares = 0;
    clk_run = 1'b0; chk_en = 1'b0; exp_known = 1'b0; rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;

    // Exhaustive 1-bit sweep with the clock stopped.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[0]; b1 = v[1]; cin1 = v[2];
      #10;
      chk("sweep_s",    {63'd0, s1},    {63'd0, (a1 ^ b1) ? ~cin1 : cin1});
      chk("sweep_cout", {63'd0, cout1}, {63'd0, (a1 ^ b1) ? cin1 : a1});
      case (i)
        0: chk("sweep_000", {62'd0, cout1, s1}, 64'h0);
        3: chk("sweep_110", {62'd0, cout1, s1}, 64'h2);
        5: chk("sweep_101", {62'd0, cout1, s1}, 64'h2);
        7: chk("sweep_111", {62'd0, cout1, s1}, 64'h3);
        default: ;
      endcase
    end
    chk("sweep_8_zero", {55'd0, cout8, s8}, 64'h0);

    // Reset held for two edges with all-ones inputs.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    clk_run = 1'b1; chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg1",  {61'd0, vld1, coutr1, sr1}, 64'h0);
    chk("rst_comb1", {62'd0, cout1, s1}, 64'h3);
    chk("rst_reg8",  {54'd0, vld8, coutr8, sr8}, 64'h0);
    chk("rst_comb8", {55'd0, cout8, s8}, 64'h1FF);

    // One-cycle registered latency.
    rst = 1'b0; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
    #1;
    chk("lat_comb",    {55'd0, cout8, s8}, 64'h100);
    chk("lat_vld_pre", {63'd0, vld8}, 64'h0);
    @(posedge clk); #1;
    chk("lat_reg", {54'd0, vld8, coutr8, sr8}, 64'h300);

    // Carry ripple extremes.
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    #1;
    chk("ripple_ff_00", {55'd0, cout8, s8}, 64'h100);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    #1;
    chk("ripple_ff_ff", {55'd0, cout8, s8}, 64'h1FF);
    @(posedge clk); #1;
    chk("ripple_reg", {54'd0, vld8, coutr8, sr8}, 64'h3FF);

    for (int i = 0; i < 4; i++) begin
      a8 = tbl_a[i]; b8 = tbl_b[i]; cin8 = tbl_c[i];
      a1 = tbl_a[i][0]; b1 = tbl_b[i][1]; cin1 = tbl_c[i];
      @(posedge clk); #1;
    end
    a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0;
    #1;
    chk("tbl_55_aa", {55'd0, cout8, s8}, 64'h0FF);

    // Mid-stream reset on the third vector.
    for (int k = 1; k <= 5; k++) begin
      a8 = 8'(k); b8 = 8'h00; cin8 = 1'b0;
      rst = (k == 3);
      @(posedge clk); #1;
      if (k == 3)
        chk("mid_rst", {54'd0, vld8, coutr8, sr8}, 64'h0);
      else
        chk("mid_stream", {54'd0, vld8, coutr8, sr8}, {54'd0, 2'b10, 8'(k)});
    end
    rst = 1'b0;

`ifdef FA_OVF_EN
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    #1;
    chk("ovf_7f_01", {62'd0, ovf8, cout8}, 64'h2);
    @(posedge clk); #1;
    chk("ovfr_7f_01", {63'd0, ovfr8}, 64'h1);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    #1;
    chk("ovf_80_80", {54'd0, ovf8, cout8, s8}, 64'h300);
    @(posedge clk); #1;
    chk("ovfr_80_80", {63'd0, ovfr8}, 64'h1);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    #1;
    chk("ovf_01_01", {63'd0, ovf8}, 64'h0);
    @(posedge clk); #1;
    chk("ovfr_01_01", {63'd0, ovfr8}, 64'h0);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fa.md
Name: fa

Overview:
- Parameterizable ripple-carry full adder.
- WIDTH=1 default is the classic 1-bit full adder (A, B, Cin -> S, Cout).
- Primary sum/carry outputs are purely combinational, for use in ALU/adder datapaths.
- A registered copy of the result, with a valid flag, is also provided for pipelined users.
- One clock; reset is synchronous and active-high.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal: 1..64).

Ports:
- clk  input  1  system clock; all registers update on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry in to bit 0.
- S  output  WIDTH  combinational sum.
- Cout  output  1  combinational carry out of MSB.
- S_r  output  WIDTH  registered S.
- Cout_r  output  1  registered Cout.
- vld_r  output  1  high when S_r/Cout_r hold a post-reset sampled result.

Behaviour:
- Combinational path, zero latency; no dependence on clk/rst:
  - Built as a chain of WIDTH 1-bit full-adder cells, c[0]=Cin.
  - Per cell: s[i] = A[i]^B[i]^c[i].
  - Per cell: c[i+1] = (A[i]^B[i]) ? c[i] : A[i].
  - Cout = c[WIDTH].
  - Equivalent check: {Cout,S} = A + B + Cin, computed at WIDTH+1 bits; no truncation of the carry.
- S and Cout settle within the same delta/timestep as the inputs; they must be valid without any clock edge.
- Registered path, 1-cycle latency:
  - On rising clk with rst=1: S_r=0, Cout_r=0, vld_r=0.
  - On rising clk with rst=0: S_r<=S, Cout_r<=Cout, vld_r<=1.
- Reset mid-operation:
  - Registered outputs clear on the next edge.
  - Combinational S/Cout keep following the inputs.
- X/Z on inputs is not handled specially and propagates per Verilog semantics.
- Boundary cases:
  - All-ones + all-ones + Cin=1 gives S = all-ones, Cout=1.
  - All-zeros with Cin=0 gives S=0, Cout=0.

Optional Feature:
- Macro: FA_OVF_EN.
- When defined, adds output ports:
  - Ovf  output  1: combinational signed overflow, Ovf = c[WIDTH]^c[WIDTH-1]. For WIDTH=1, c[0]=Cin.
  - Ovf_r  output  1: registered copy, same reset and timing as Cout_r.
- When not defined:
  - Ovf/Ovf_r ports and their logic are absent.
  - All other behaviour is identical.

Test Plan:
- Exhaustive 1-bit sweep, WIDTH=1: i=0..7 drives A=i[0], B=i[1], Cin=i[2], then wait 10 time units with no clock. Required: S=(A^B)?~Cin:Cin and Cout=(A^B)?Cin:A. Vectors (0,0,0)->(0,0), (1,1,0)->(0,1), (1,0,1)->(0,1), (1,1,1)->(1,1).
- Reset: rst=1 for 2 edges with A=1, B=1, Cin=1. Required: S_r=0, Cout_r=0, vld_r=0, while S=1 and Cout=1 combinationally.
- Registered latency, WIDTH=8: deassert rst, apply A=8'hF0, B=8'h0F, Cin=1. Required: S=8'h00, Cout=1 immediately; S_r=8'h00, Cout_r=1, vld_r=1 after exactly one edge.
- Carry ripple extreme, WIDTH=8: A=8'hFF, B=8'h00, Cin=1 -> S=8'h00, Cout=1. A=8'hFF, B=8'hFF, Cin=1 -> S=8'hFF, Cout=1.
- Mid-stream reset, WIDTH=8: stream A=1..5, B=0, Cin=0, asserting rst for one edge at the third vector. Required: registered outputs read 0 with vld_r=0 on that cycle, then resume with the next vector.
- FA_OVF_EN, WIDTH=8: A=8'h7F, B=8'h01, Cin=0 -> Ovf=1, Cout=0. A=8'h80, B=8'h80, Cin=0 -> Ovf=1, Cout=1, S=8'h00. A=8'h01, B=8'h01 -> Ovf=0. Ovf_r follows one edge later.
